// File: rtl/ad7606_read_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the AD7606 read sequencer: FSM state codes,
// pin level names, default frame sync word and a saturating counter helper.
package ad7606_read_sequencer_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_CONVST       = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY_LO = 3'd3;
  localparam logic [2:0] ST_HEADER       = 3'd4;
  localparam logic [2:0] ST_RD_LO        = 3'd5;
  localparam logic [2:0] ST_RD_HI        = 3'd6;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA5A5;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/daq_conv_timer.sv
`timescale 1ns/1ps
// Conversion period timer: counts 0..CONV_PERIOD-1 while enabled, held at 0
// otherwise. tick_o marks count 0, so the first tick comes right at enable.
module daq_conv_timer #(
  parameter int CONV_PERIOD = 500
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (CONV_PERIOD > 2) ? $clog2(CONV_PERIOD) : 1;

  logic [CW-1:0] count_reg;

  // Free-running period counter, parked at zero while disabled
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_reg <= '0;
    end else if (!enable_i) begin
      count_reg <= '0;
    end else if (count_reg == CW'(CONV_PERIOD - 1)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick_o = enable_i && (count_reg == '0);

endmodule

// File: rtl/ad7606_read_sequencer.sv
`timescale 1ns/1ps
// AD7606 read sequencer: per period tick pulses CONVST, waits out BUSY,
// reads NUM_CH words over CS/RD and writes sync header + samples to the FIFO.
// Build option: define ADSEQ_TIMESTAMP_EN to append a 32-bit frame number
// (high half, then low half) after the sync word.
module ad7606_read_sequencer
  import ad7606_read_sequencer_pkg::*;
#(
  parameter int          CONV_PERIOD  = 500,
  parameter int          CONVST_LOW   = 50,
  parameter int          NUM_CH       = 8,
  parameter int          RD_LOW       = 3,
  parameter int          RD_HIGH      = 2,
  parameter int          BUSY_TIMEOUT = 16,
  parameter logic [15:0] SYNC_WORD    = DEFAULT_SYNC_WORD
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [2:0]  os_sel_i,
  output logic [2:0]  os_o,
  output logic        convst_o,
  input  logic        busy_i,
  input  logic        frstdata_i,
  output logic        cs_n_o,
  output logic        rd_n_o,
  input  logic [15:0] db_i,
  output logic [15:0] fifo_data_o,
  output logic        fifo_wrreq_o,
  input  logic        fifo_wrfull_i,
  output logic        overrun_o,
  output logic        frame_err_o,
  output logic [15:0] drop_cnt_o
);

  localparam logic [15:0] CONVST_END = 16'(CONVST_LOW - 1);
  localparam logic [15:0] TIMEOUT_END = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] RD_LO_END = 16'(RD_LOW - 1);
  localparam logic [15:0] RD_HI_END = 16'(RD_HIGH - 1);
  localparam logic [3:0]  LAST_CH = 4'(NUM_CH - 1);

  logic        tick;
  logic [2:0]  state_reg;
  logic [15:0] cnt_reg;
  logic [3:0]  ch_reg;
  logic        busy_meta_reg, busy_sync_reg;
  logic        convst_reg, cs_n_reg, rd_n_reg;
  logic        wrreq_reg, overrun_reg, frame_err_reg;
  logic [15:0] data_reg, drop_cnt_reg;
  logic [2:0]  os_reg;
  logic        dropped_reg, ferr_seen_reg;
  logic [15:0] hdr_word;
  logic        hdr_last;
  logic        frame_done;
  logic        frst_bad;

  daq_conv_timer #(.CONV_PERIOD(CONV_PERIOD)) u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .tick_o   (tick)
  );

  // Last RD-high cycle of the last channel closes the frame
  assign frame_done = (state_reg == ST_RD_HI) && (cnt_reg == RD_HI_END) && (ch_reg == LAST_CH);
  // FRSTDATA must be high exactly on channel 0
  assign frst_bad = (ch_reg == 4'd0) ? !frstdata_i : frstdata_i;

`ifdef ADSEQ_TIMESTAMP_EN
  logic [1:0]  hdr_idx_reg;
  logic [31:0] frame_no_reg;

  // Header slot index and frame number (counts every finished read, dropped or not)
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_idx_reg  <= 2'd0;
      frame_no_reg <= 32'd0;
    end else begin
      if (state_reg == ST_HEADER) hdr_idx_reg <= hdr_last ? 2'd0 : hdr_idx_reg + 2'd1;
      if (frame_done) frame_no_reg <= frame_no_reg + 32'd1;
    end
  end

  // Header word select: sync, frame_no high half, frame_no low half
  always_comb begin
    hdr_word = SYNC_WORD;
    hdr_last = (hdr_idx_reg == 2'd2);
    if (hdr_idx_reg == 2'd1)      hdr_word = frame_no_reg[31:16];
    else if (hdr_idx_reg == 2'd2) hdr_word = frame_no_reg[15:0];
  end
`else
  assign hdr_word = SYNC_WORD;
  assign hdr_last = 1'b1;
`endif

  // Two-stage synchroniser for the asynchronous BUSY line
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_meta_reg <= LO;
      busy_sync_reg <= LO;
    end else begin
      busy_meta_reg <= busy_i;
      busy_sync_reg <= busy_meta_reg;
    end
  end

  // Conversion / read sequencer with registered pin and FIFO outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 16'd0;
      ch_reg        <= 4'd0;
      convst_reg    <= HI;
      cs_n_reg      <= HI;
      rd_n_reg      <= HI;
      wrreq_reg     <= LO;
      data_reg      <= 16'd0;
      os_reg        <= 3'd0;
      overrun_reg   <= LO;
      frame_err_reg <= LO;
      drop_cnt_reg  <= 16'd0;
      dropped_reg   <= LO;
      ferr_seen_reg <= LO;
    end else begin
      wrreq_reg     <= LO;
      overrun_reg   <= LO;
      frame_err_reg <= LO;
      // A tick arriving mid-frame is lost; flag it but do not count it as a drop
      if (tick && state_reg != ST_IDLE) overrun_reg <= HI;
      case (state_reg)
        ST_IDLE: begin
          os_reg <= os_sel_i;
          if (tick) begin
            convst_reg <= LO;
            cnt_reg    <= 16'd0;
            state_reg  <= ST_CONVST;
          end
        end
        ST_CONVST: begin
          if (cnt_reg == CONVST_END) begin
            convst_reg <= HI;
            cnt_reg    <= 16'd0;
            state_reg  <= ST_WAIT_BUSY_HI;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_WAIT_BUSY_HI: begin
          if (busy_sync_reg) begin
            state_reg <= ST_WAIT_BUSY_LO;
          end else if (cnt_reg == TIMEOUT_END) begin
            frame_err_reg <= HI;
            state_reg     <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_WAIT_BUSY_LO: begin
          if (!busy_sync_reg) begin
            dropped_reg   <= LO;
            ferr_seen_reg <= LO;
            state_reg     <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          data_reg <= hdr_word;
          if (!dropped_reg && !fifo_wrfull_i) wrreq_reg <= HI;
          else dropped_reg <= HI;
          if (hdr_last) begin
            cs_n_reg  <= LO;
            rd_n_reg  <= LO;
            cnt_reg   <= 16'd0;
            ch_reg    <= 4'd0;
            state_reg <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (cnt_reg == RD_LO_END) begin
            // Sample on the last low cycle; write lands on the following cycle
            data_reg <= db_i;
            if (!dropped_reg && !fifo_wrfull_i) wrreq_reg <= HI;
            else dropped_reg <= HI;
            if (frst_bad && !ferr_seen_reg) frame_err_reg <= HI;
            ferr_seen_reg <= ferr_seen_reg | frst_bad;
            rd_n_reg  <= HI;
            cnt_reg   <= 16'd0;
            state_reg <= ST_RD_HI;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_RD_HI: begin
          if (frame_done) begin
            cs_n_reg  <= HI;
            cnt_reg   <= 16'd0;
            state_reg <= ST_IDLE;
            if (dropped_reg) begin
              overrun_reg  <= HI;
              drop_cnt_reg <= sat_inc16(drop_cnt_reg);
            end
          end else if (cnt_reg == RD_HI_END) begin
            ch_reg    <= ch_reg + 4'd1;
            rd_n_reg  <= LO;
            cnt_reg   <= 16'd0;
            state_reg <= ST_RD_LO;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign os_o         = os_reg;
  assign convst_o     = convst_reg;
  assign cs_n_o       = cs_n_reg;
  assign rd_n_o       = rd_n_reg;
  assign fifo_data_o  = data_reg;
  assign fifo_wrreq_o = wrreq_reg;
  assign overrun_o    = overrun_reg;
  assign frame_err_o  = frame_err_reg;
  assign drop_cnt_o   = drop_cnt_reg;

endmodule

// File: tb/tb_ad7606_read_sequencer.sv
`timescale 1ns/1ps
// Bench for ad7606_read_sequencer: behavioural AD7606 + FIFO model, frame
// expectations built from the sync/sample framing rules, one line per frame.
module tb_ad7606_read_sequencer;
  import ad7606_read_sequencer_pkg::*;

  localparam int NUM_CH = 8;
  localparam int BUSY_TIMEOUT = 16;
`ifdef ADSEQ_TIMESTAMP_EN
  localparam int HDR_W = 3;
`else
  localparam int HDR_W = 1;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [2:0]  os_sel_i = 3'd0;
  logic [2:0]  os_o;
  logic        convst_o;
  logic        busy_i = 1'b0;
  logic        frstdata_i = 1'b0;
  logic        cs_n_o, rd_n_o;
  logic [15:0] db_i = 16'd0;
  logic [15:0] fifo_data_o;
  logic        fifo_wrreq_o;
  logic        fifo_wrfull_i = 1'b0;
  logic        overrun_o, frame_err_o;
  logic [15:0] drop_cnt_o;

  ad7606_read_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .os_sel_i(os_sel_i), .os_o(os_o),
    .convst_o(convst_o), .busy_i(busy_i), .frstdata_i(frstdata_i), .cs_n_o(cs_n_o), .rd_n_o(rd_n_o),
    .db_i(db_i), .fifo_data_o(fifo_data_o), .fifo_wrreq_o(fifo_wrreq_o), .fifo_wrfull_i(fifo_wrfull_i),
    .overrun_o(overrun_o), .frame_err_o(frame_err_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // ADC model state
  logic [15:0] adc_data [NUM_CH];
  int busy_len = 400;
  bit busy_stuck = 0;
  bit frst_bad = 0;
  int conv_id = 0;
  int conv_seen = 0;
  int rd_idx = 0;
  int rd_count = 0;

  // Monitor state
  logic [15:0] got[$];
  int ovr_cnt = 0, ferr_cnt = 0, cyc = 0;
  int last_fall = -1, conv_period = 0, conv_width = 0, low_cnt = 0;
  logic convst_prev = 1'b1;

  // Reference model state
  logic [31:0] model_fno = 32'd0;
  int model_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC BUSY: rises shortly after CONVST rising edge, lasts busy_len cycles
  always begin
    @(posedge convst_o);
    if (!busy_stuck && reset_i === 1'b0) begin
      conv_id++;
      #3 busy_i = 1'b1;
      repeat (busy_len) @(posedge clk_i);
      #3 busy_i = 1'b0;
    end
  end

  // ADC parallel read: next channel presented after each RD falling edge
  always begin
    @(negedge rd_n_o);
    #1;
    if (cs_n_o === 1'b0) begin
      if (conv_seen != conv_id) begin
        rd_idx = 0;
        conv_seen = conv_id;
      end
      db_i = adc_data[rd_idx];
      frstdata_i = (rd_idx == 0) || (frst_bad && rd_idx == 2);
      rd_idx = (rd_idx + 1) % NUM_CH;
      rd_count++;
    end
  end

  // FIFO capture, pulse counting and CONVST timing
  always @(negedge clk_i) begin
    cyc++;
    if (fifo_wrreq_o === 1'b1) got.push_back(fifo_data_o);
    if (overrun_o === 1'b1) ovr_cnt++;
    if (frame_err_o === 1'b1) ferr_cnt++;
    if (convst_prev === 1'b1 && convst_o === 1'b0) begin
      if (last_fall >= 0) conv_period = cyc - last_fall;
      last_fall = cyc;
      low_cnt = 0;
    end
    if (convst_o === 1'b0) low_cnt++;
    if (convst_prev === 1'b0 && convst_o === 1'b1) conv_width = low_cnt;
    convst_prev = convst_o;
  end

  // mode: 0 normal, 1 FIFO full at header, 2 full after ch3, 3 FRSTDATA glitch
  task automatic do_frame(input string tag, input int blen, input int mode,
                          input int exp_ovr, input int exp_ferr);
    int base, o0, f0, r0, n, nw;
    bit seen_low, done;
    logic [15:0] exp_q[$];
    base = got.size(); o0 = ovr_cnt; f0 = ferr_cnt; r0 = rd_count;
    busy_len = blen;
    frst_bad = (mode == 3);
    if (mode == 1) fifo_wrfull_i = 1'b1;
    seen_low = 0; done = 0;
    for (n = 0; n < 1500 && !done; n++) begin
      @(negedge clk_i);
      if (mode == 2 && (got.size() - base) >= HDR_W + 4) fifo_wrfull_i = 1'b1;
      if (cs_n_o === 1'b0) seen_low = 1;
      else if (seen_low) done = 1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk_i);
    fifo_wrfull_i = 1'b0;
    frst_bad = 0;
    exp_q.delete();
    if (mode != 1) begin
      exp_q.push_back(DEFAULT_SYNC_WORD);
`ifdef ADSEQ_TIMESTAMP_EN
      exp_q.push_back(model_fno[31:16]);
      exp_q.push_back(model_fno[15:0]);
`endif
      for (int i = 0; i < NUM_CH; i++)
        if (mode != 2 || i < 4) exp_q.push_back(adc_data[i]);
    end
    model_fno = model_fno + 32'd1;
    if (mode == 1 || mode == 2) model_drop++;
    nw = got.size() - base;
    check({tag, "_nwords"}, nw, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < nw) check($sformatf("%s_w%0d", tag, i), 32'(got[base + i]), 32'(exp_q[i]));
    check({tag, "_overrun"}, ovr_cnt - o0, exp_ovr);
    check({tag, "_frame_err"}, ferr_cnt - f0, exp_ferr);
    check({tag, "_rd_pulses"}, rd_count - r0, NUM_CH);
    check({tag, "_drop_cnt"}, 32'(drop_cnt_o), model_drop);
    $display("frame %s: words=%0d rd=%0d overrun=%0d frame_err=%0d drop_cnt=%0d",
             tag, nw, rd_count - r0, ovr_cnt - o0, ferr_cnt - f0, drop_cnt_o);
  endtask

  initial begin
    int n, lat, base, f0, o0;
    bit rose, seen;
    logic prev;
    logic [2:0] os_req;

    repeat (3) @(negedge clk_i);
    check("rst_convst", 32'(convst_o), 32'd1);
    check("rst_cs_n", 32'(cs_n_o), 32'd1);
    check("rst_rd_n", 32'(rd_n_o), 32'd1);
    check("rst_wrreq", 32'(fifo_wrreq_o), 32'd0);
    check("rst_data", 32'(fifo_data_o), 32'd0);
    check("rst_os", 32'(os_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_frame_err", 32'(frame_err_o), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);

    os_req = 3'($urandom_range(7, 1));
    os_sel_i = os_req;
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("os_latch", 32'(os_o), 32'(os_req));
    enable_i = 1'b1;

    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'h1000 + 16'(i);
    do_frame("ramp", 400, 0, 0, 0);
    check("convst_width", conv_width, 50);

    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
    do_frame("rand1", 400, 0, 0, 0);
    check("convst_period", conv_period, 500);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
      do_frame($sformatf("rand%0d", k + 2), $urandom_range(300, 30), 0, 0, 0);
    end

    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
    do_frame("full_hdr", $urandom_range(300, 30), 1, 1, 0);
    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
    do_frame("full_mid", $urandom_range(300, 30), 2, 1, 0);
    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
    do_frame("frst_glitch", $urandom_range(300, 30), 3, 0, 1);
    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
    do_frame("late_busy", 470, 0, 1, 0);

    // BUSY never rises: timeout error after BUSY_TIMEOUT cycles, nothing written
    busy_stuck = 1;
    base = got.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    prev = convst_o; rose = 0;
    for (n = 0; n < 1000 && !rose; n++) begin
      @(negedge clk_i);
      if (prev === 1'b0 && convst_o === 1'b1) rose = 1;
      prev = convst_o;
    end
    check("stuck_convst_rise", 32'(rose), 32'd1);
    lat = 0; seen = 0;
    for (n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_i);
      lat++;
      if (frame_err_o === 1'b1) seen = 1;
    end
    check("stuck_latency", lat, BUSY_TIMEOUT);
    repeat (5) @(negedge clk_i);
    busy_stuck = 0;
    check("stuck_nwords", got.size() - base, 0);
    check("stuck_frame_err", ferr_cnt - f0, 1);
    check("stuck_overrun", ovr_cnt - o0, 0);
    check("stuck_drop_cnt", 32'(drop_cnt_o), model_drop);
    $display("frame busy_stuck: timeout after %0d cycles", lat);

    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
    do_frame("resume", $urandom_range(300, 30), 0, 0, 0);

    // Reset in the middle of the read loop
    seen = 0;
    for (n = 0; n < 1500 && !seen; n++) begin
      @(negedge clk_i);
      if (cs_n_o === 1'b0) seen = 1;
    end
    check("midrst_cs_low", 32'(seen), 32'd1);
    repeat (7) @(negedge clk_i);
    #1 reset_i = 1'b1;
    #1;
    check("midrst_cs_n", 32'(cs_n_o), 32'd1);
    check("midrst_rd_n", 32'(rd_n_o), 32'd1);
    check("midrst_wrreq", 32'(fifo_wrreq_o), 32'd0);
    check("midrst_data", 32'(fifo_data_o), 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    $display("frame mid_reset: reset applied inside read loop");
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    model_fno = 32'd0;
    model_drop = 0;
    for (int i = 0; i < NUM_CH; i++) adc_data[i] = 16'($urandom);
    do_frame("post_reset", $urandom_range(300, 30), 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
